// File: rtl/pdp11_mmu.sv
// pdp11_mmu: PDP-11 memory-management unit, 16-bit virtual to 22-bit physical.
// Ports:
//   clk, reset (async, active-low)
//   cpu_va/cpu_cm/cpu_rd/cpu_wr/cpu_i_access/fetch_va : CPU access in
//   cpu_pa, signal_abort, signal_trap                 : translation out (combinational)
//   pxr_rd/pxr_wr/pxr_addr/pxr_data_in/pxr_data_out    : PAR/PDR/SR0-SR3 register port
// Optional feature macro: MMU_SUPERVISOR_EN (supervisor PAR/PDR set and SR3[1]).
module pdp11_mmu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_va,
    input  logic [1:0]  cpu_cm,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_i_access,
    input  logic        fetch_va,
    output logic [21:0] cpu_pa,
    output logic        signal_abort,
    output logic        signal_trap,
    input  logic        pxr_rd,
    input  logic        pxr_wr,
    input  logic [7:0]  pxr_addr,
    input  logic [15:0] pxr_data_in,
    output logic [15:0] pxr_data_out
);
    logic [15:0] r_par [3][2][8];
    logic [15:0] r_pdr [3][2][8];
    logic [15:0] r_sr0, r_sr2, r_sr3;
    logic        w_sup_en;
`ifdef MMU_SUPERVISOR_EN
    assign w_sup_en = 1'b1;
`else
    assign w_sup_en = 1'b0;
`endif
    logic        w_map, w_acc, w_bad_mode, w_dsp, w_nr, w_le, w_ro, w_tacf, w_ed;
    logic [1:0]  w_midx;
    logic [2:0]  w_apf, w_acf;
    logic [6:0]  w_blk, w_plf;
    logic [15:0] w_par, w_pdr;
    logic [21:0] w_sum;
    assign w_map      = r_sr0[0];
    assign w_acc      = cpu_rd | cpu_wr;
    assign w_apf      = cpu_va[15:13];
    assign w_blk      = cpu_va[12:6];
    // mode 10 indexes the kernel set but is aborted regardless
    assign w_midx     = (cpu_cm == 2'b11) ? 2'd2 : {1'b0, cpu_cm[0]};
    assign w_bad_mode = (cpu_cm == 2'b10) | ((cpu_cm == 2'b01) & ~w_sup_en);
    assign w_dsp      = ~cpu_i_access & ((cpu_cm == 2'b00) ? r_sr3[2] :
                                         (cpu_cm == 2'b01) ? (r_sr3[1] & w_sup_en) :
                                         (cpu_cm == 2'b11) ? r_sr3[0] : 1'b0);
    assign w_par      = r_par[w_midx][w_dsp][w_apf];
    assign w_pdr      = r_pdr[w_midx][w_dsp][w_apf];
    assign w_acf      = w_pdr[2:0];
    assign w_plf      = w_pdr[14:8];
    assign w_ed       = w_pdr[3];
    assign w_sum      = {w_par, 6'b0} + {9'b0, cpu_va[12:0]};
    assign w_nr       = w_bad_mode | (w_acf == 3'd0) | (w_acf == 3'd3) | (w_acf == 3'd7);
    assign w_le       = ~w_bad_mode & (w_ed ? (w_blk < w_plf) : (w_blk > w_plf));
    assign w_ro       = ~w_bad_mode & cpu_wr & ((w_acf == 3'd1) | (w_acf == 3'd2));
    assign w_tacf     = ~w_bad_mode & ((w_acf == 3'd4) | ((w_acf == 3'd1) & cpu_rd) |
                                       ((w_acf == 3'd5) & cpu_wr));
    // 18-bit mode: the top 8 KB of the 18-bit space aliases the 22-bit I/O page
    assign cpu_pa = !w_map ? ((&cpu_va[15:13]) ? {9'h1FF, cpu_va[12:0]} : {6'b0, cpu_va}) :
                    r_sr3[4] ? w_sum : {(&w_sum[17:13]) ? 4'hF : 4'h0, w_sum[17:0]};
    assign signal_abort = w_acc & w_map & (w_nr | w_le | w_ro);
    assign signal_trap  = w_acc & w_map & r_sr0[9] & w_tacf & ~signal_abort;
    logic        w_ctl, w_pok, w_unused;
    logic [1:0]  w_pm;
    logic [15:0] w_rdata;
    assign w_ctl    = pxr_addr[7:6] == 2'b10;
    assign w_pm     = (pxr_addr[7:6] == 2'b11) ? 2'd2 : {1'b0, pxr_addr[6]};
    assign w_pok    = ~w_ctl & ((pxr_addr[7:6] != 2'b01) | w_sup_en);
    assign w_unused = pxr_addr[0];
    always_comb begin
        w_rdata = 16'h0;
        if (w_ctl)
            w_rdata = (pxr_addr[2:1] == 2'd0) ? r_sr0 :
                      (pxr_addr[2:1] == 2'd2) ? r_sr2 :
                      (pxr_addr[2:1] == 2'd3) ? r_sr3 : 16'h0;
        else if (w_pok)
            w_rdata = pxr_addr[5] ? r_par[w_pm][pxr_addr[4]][pxr_addr[3:1]]
                                  : r_pdr[w_pm][pxr_addr[4]][pxr_addr[3:1]];
    end
    assign pxr_data_out = pxr_rd ? w_rdata : 16'h0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr0 <= 16'h0;
            r_sr2 <= 16'h0;
            r_sr3 <= 16'h0;
            for (int m = 0; m < 3; m++)
                for (int s = 0; s < 2; s++)
                    for (int p = 0; p < 8; p++) begin
                        r_par[m][s][p] <= 16'h0;
                        r_pdr[m][s][p] <= 16'h0;
                    end
        end else begin
            if (w_acc & w_map) begin
                if (signal_abort) begin
                    // the first abort's status is held until software clears SR0[15:13]
                    if (r_sr0[15:13] == 3'b000)
                        r_sr0 <= {w_nr, w_le, w_ro, r_sr0[12:7], cpu_cm, w_dsp, w_apf, r_sr0[0]};
                end else begin
                    if (signal_trap)
                        r_sr0[12] <= 1'b1;
                    r_pdr[w_midx][w_dsp][w_apf][6] <= 1'b1;
                    if (cpu_wr)
                        r_pdr[w_midx][w_dsp][w_apf][7] <= 1'b1;
                end
            end
            if (fetch_va & cpu_rd & (r_sr0[15:13] == 3'b000))
                r_sr2 <= cpu_va;
            // register-port writes come last so they win over same-cycle status updates
            if (pxr_wr) begin
                if (w_ctl) begin
                    if (pxr_addr[2:1] == 2'd0)
                        r_sr0 <= (r_sr0 & ~16'hF27F) | (pxr_data_in & 16'hF27F);
                    if (pxr_addr[2:1] == 2'd3)
                        r_sr3 <= pxr_data_in & 16'h0017;
                end else if (w_pok) begin
                    if (pxr_addr[5])
                        r_par[w_pm][pxr_addr[4]][pxr_addr[3:1]] <= pxr_data_in;
                    else
                        r_pdr[w_pm][pxr_addr[4]][pxr_addr[3:1]] <= pxr_data_in & 16'h7F0F;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdp11_mmu.sv
// tb_pdp11_mmu: scoreboard bench for pdp11_mmu translation, aborts, traps and SR registers.
module tb_pdp11_mmu;
    logic        clk = 1'b0, reset = 1'b0;
    logic [15:0] cpu_va;
    logic [1:0]  cpu_cm;
    logic        cpu_rd, cpu_wr, cpu_i_access, fetch_va;
    logic [21:0] cpu_pa;
    logic        signal_abort, signal_trap;
    logic        pxr_rd, pxr_wr;
    logic [7:0]  pxr_addr;
    logic [15:0] pxr_data_in, pxr_data_out;
    localparam logic [7:0] KIPDR0 = 8'h00, KIPDR1 = 8'h02, KIPAR0 = 8'h20;
    localparam logic [7:0] KDPDR0 = 8'h10, KDPAR0 = 8'h30, SPDR0 = 8'h40;
    localparam logic [7:0] UIPDR0 = 8'hC0, UIPAR0 = 8'hE0;
    localparam logic [7:0] SR0 = 8'h80, SR1 = 8'h82, SR2 = 8'h84, SR3 = 8'h86;
    pdp11_mmu dut (
        .clk(clk), .reset(reset), .cpu_va(cpu_va), .cpu_cm(cpu_cm), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_i_access(cpu_i_access), .fetch_va(fetch_va), .cpu_pa(cpu_pa),
        .signal_abort(signal_abort), .signal_trap(signal_trap), .pxr_rd(pxr_rd),
        .pxr_wr(pxr_wr), .pxr_addr(pxr_addr), .pxr_data_in(pxr_data_in),
        .pxr_data_out(pxr_data_out)
    );
    always #5 clk = ~clk;
    typedef struct {string tag; logic [23:0] exp; bit acc;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0;
    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask
    task automatic clear_in();
        cpu_va = 16'h0; cpu_cm = 2'b00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_i_access = 1'b1; fetch_va = 1'b0;
        pxr_rd = 1'b0; pxr_wr = 1'b0; pxr_addr = 8'h0; pxr_data_in = 16'h0;
    endtask
    task automatic step();
        exp_t e;
        @(negedge clk);
        e = q.pop_front();
        check(e.tag, e.acc ? {signal_abort, signal_trap, cpu_pa} : {8'h0, pxr_data_out}, e.exp);
    endtask
    // expected word for an access: {abort, trap, pa}
    task automatic acc(input string tag, input logic rd, input logic wr, input logic [1:0] cm,
                       input logic ia, input logic f, input logic [15:0] va,
                       input logic [21:0] pa, input logic ab, input logic tr);
        @(posedge clk); #1;
        clear_in();
        cpu_rd = rd; cpu_wr = wr; cpu_cm = cm; cpu_i_access = ia; fetch_va = f; cpu_va = va;
        q.push_back('{tag, {ab, tr, pa}, 1'b1});
        step();
    endtask
    task automatic rreg(input string tag, input logic rd, input logic [7:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        clear_in();
        pxr_rd = rd; pxr_addr = a;
        q.push_back('{tag, {8'h0, v}, 1'b0});
        step();
    endtask
    task automatic wreg(input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        clear_in();
        pxr_wr = 1'b1; pxr_addr = a; pxr_data_in = d;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        clear_in();
        rreg("rst_sr0", 1'b1, SR0, 16'h0);
        acc("rst_pa", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'o001000, 22'o001000, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        acc("off_rd", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o001000, 22'o001000, 1'b0, 1'b0);
        acc("off_io", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o177560, 22'o17777560, 1'b0, 1'b0);
        acc("off_sup", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 16'o001000, 22'o001000, 1'b0, 1'b0);
        wreg(KIPAR0, 16'o2000);
        wreg(KIPDR0, 16'o077406);
        wreg(SR3, 16'o20);
        wreg(SR0, 16'o1);
        rreg("sr3", 1'b1, SR3, 16'o20);
        rreg("sr0_en", 1'b1, SR0, 16'o1);
        rreg("rd_off", 1'b0, SR3, 16'h0);
        rreg("pdr0", 1'b1, KIPDR0, 16'o077406);
        acc("map_rd", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b0);
        rreg("pdr0_a", 1'b1, KIPDR0, 16'o077506);
        wreg(KIPAR0, 16'o7600);
        acc("pa22", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o760100, 1'b0, 1'b0);
        wreg(SR3, 16'o0);
        acc("pa18", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o17760100, 1'b0, 1'b0);
        wreg(KIPAR0, 16'o2000);
        wreg(KDPAR0, 16'o4000);
        wreg(KDPDR0, 16'o077406);
        wreg(SR3, 16'o24);
        acc("dspace", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'o000100, 22'o400100, 1'b0, 1'b0);
        acc("ispace", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b0);
        wreg(SR3, 16'o20);
        wreg(KIPDR0, 16'o000406);
        acc("plf_eq", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b0);
        wreg(KIPDR0, 16'o001016);
        acc("ed_eq", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000200, 22'o200200, 1'b0, 1'b0);
        wreg(KIPDR0, 16'o000006);
        acc("len_ab", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b1, 1'b0);
        rreg("sr0_len", 1'b1, SR0, 16'o040001);
        acc("nr_ab", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'o020000, 22'o0, 1'b1, 1'b0);
        rreg("sr0_frz", 1'b1, SR0, 16'o040001);
        wreg(SR0, 16'o1);
        wreg(UIPAR0, 16'o1000);
        wreg(UIPDR0, 16'o077402);
        acc("u_wr_ro", 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 16'o000100, 22'o100100, 1'b1, 1'b0);
        rreg("sr0_ro", 1'b1, SR0, 16'o020141);
        acc("u_rd_ro", 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 16'o000100, 22'o100100, 1'b0, 1'b0);
        wreg(SR0, 16'o1001);
        wreg(KIPDR0, 16'o077405);
        acc("trap_wr", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b1);
        rreg("sr0_trap", 1'b1, SR0, 16'o011001);
        rreg("pdr0_aw", 1'b1, KIPDR0, 16'o077705);
        acc("trap_rd5", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b0);
        wreg(KIPDR0, 16'o077404);
        acc("trap_rd4", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o000100, 22'o200100, 1'b0, 1'b1);
        wreg(SR0, 16'o1);
        acc("fetch", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 16'o001234, 22'o201234, 1'b0, 1'b0);
        rreg("sr2", 1'b1, SR2, 16'o001234);
        acc("nr_ab2", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 16'o020000, 22'o0, 1'b1, 1'b0);
        acc("fetch2", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 16'o000500, 22'o200500, 1'b0, 1'b0);
        wreg(SR2, 16'o777);
        rreg("sr2_frz", 1'b1, SR2, 16'o001234);
        rreg("sr1", 1'b1, SR1, 16'h0);
        wreg(SR0, 16'o1);
        wreg(SPDR0, 16'o077406);
`ifdef MMU_SUPERVISOR_EN
        rreg("s_pdr", 1'b1, SPDR0, 16'o077406);
        acc("s_acc", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 16'o000100, 22'o000100, 1'b0, 1'b0);
        rreg("sr0_s", 1'b1, SR0, 16'o000001);
`else
        rreg("s_pdr", 1'b1, SPDR0, 16'h0);
        acc("s_acc", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 16'o000100, 22'o000100, 1'b1, 1'b0);
        rreg("sr0_s", 1'b1, SR0, 16'o100041);
`endif
        @(posedge clk); #1;
        clear_in();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pdp11_mmu.md
# pdp11_mmu

Memory-management unit for the PDP-11 core, placed between the CPU's 16-bit virtual bus address and the 22-bit physical bus. It translates each CPU access through per-mode page registers (PAR/PDR) and raises abort or trap conditions back to the CPU. It also hosts the SR0–SR3 status registers, which the I/O-page decoder reads and writes over the pxr port.

## Interface
- Parameters: none.
- clk  in  1  system clock; all register updates happen on its rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears every register.
- cpu_va  in  16  virtual address of the current CPU access.
- cpu_cm  in  2  current mode: 00 kernel, 01 supervisor, 11 user, 10 illegal.
- cpu_rd / cpu_wr  in  1  access strobes; held for the whole access.
- cpu_i_access  in  1  1 = instruction-space access, 0 = data-space access.
- fetch_va  in  1  the current read is an instruction fetch.
- cpu_pa  out  22  physical address; combinational.
- signal_abort  out  1  the access is aborted; combinational.
- signal_trap  out  1  a memory-management trap is requested; combinational.
- pxr_rd / pxr_wr  in  1  register read and word-write strobes.
- pxr_addr  in  8  register select, decoded as follows:
  - [7:6] selects the set: 00 kernel, 01 supervisor, 11 user, 10 control.
  - [5] 1 = PAR, 0 = PDR.
  - [4] 1 = D-space, 0 = I-space.
  - [3:1] page number; [0] is ignored.
  - Control set: [2:1] selects SR0, SR1, SR2 or SR3.
- pxr_data_in  in  16  write data.
- pxr_data_out  out  16  register read data; 0 when pxr_rd=0.

## Operation
- Storage: 3 modes × {I,D} × 8 pages × {PAR,PDR}, 16 bits each, plus SR0, SR2 and SR3. SR1 always reads 0.
- Mapping is enabled when SR0[0]=1.
- Disabled mapping:
  - cpu_pa = {6'b0, cpu_va}.
  - If cpu_va[15:13]=111, cpu_pa = {9'h1FF, cpu_va[12:0]} (I/O page).
  - No aborts and no traps.
- Enabled mapping, address split: apf = va[15:13], block = va[12:6], disp = va[5:0].
- Space selection: D-space is used when cpu_i_access=0 and SR3 enables D-space for the mode. SR3 bit 2 = kernel, bit 1 = supervisor, bit 0 = user. Otherwise I-space is used.
- Address formation: pa = {PAR, 6'b0} + {block, disp}, truncated to 22 bits.
- If SR3[4]=0 (18-bit mode):
  - pa[21:18] = 1111 when pa[17:13]=11111.
  - Otherwise pa[21:18] = 0000.
- PDR fields: [14:8] PLF, [7] W, [6] A, [3] ED, [2:0] ACF.
- ACF decode (3 bits):
  - 0, 3 and 7: non-resident.
  - 1: read-only, trap on read.
  - 2: read-only.
  - 4: read/write, trap on any access.
  - 5: read/write, trap on write.
  - 6: read/write.
- Page-length error:
  - ED=0: error when block > PLF.
  - ED=1: error when block < PLF.
- Abort conditions (evaluated when (cpu_rd|cpu_wr) and mapping is enabled):
  - non-resident ACF;
  - page-length error;
  - write to a read-only page;
  - cpu_cm=10.
- Trap condition: the access matches a trap ACF, SR0[9]=1, and there is no abort.
- Clocked updates on each access cycle:
  - Abort with SR0[15:13]=000: set SR0[15] (non-resident), SR0[14] (length) and SR0[13] (read-only) as applicable. Load SR0[6:5] = cpu_cm, SR0[4] = the D-space selection, SR0[3:1] = apf.
  - Abort with SR0[15:13] nonzero: SR0 is frozen and does not change.
  - Trap: set SR0[12].
  - Successful access: set PDR A; also set W on a write.
  - fetch_va & cpu_rd with SR0[15:13]=000: SR2 ← cpu_va.
- pxr writes:
  - SR0 writable mask is 16'hF27F.
  - SR3 writable mask is 16'h0017.
  - SR2 is read-only.
  - A PDR write stores bits 14:8, 3 and 2:0, and clears A and W.
  - PARs are fully writable.
- A pxr_wr in the same cycle as an abort, trap or A/W update wins for the addressed register.

## Timing
- Translation, signal_abort, signal_trap and pxr_data_out are all zero-latency combinational paths.
- Register updates (SR0, SR2, A/W, pxr writes) take effect on the next rising edge of clk.
- Strobes held for multiple cycles repeat the same updates; the updates are idempotent.
- At reset:
  - all registers are 0, so mapping is disabled;
  - cpu_pa follows the disabled mapping;
  - signal_abort = 0, signal_trap = 0, pxr_data_out = 0.

## Configuration
- MMU_SUPERVISOR_EN:
  - Defined: supervisor mode has its own PAR/PDR set and SR3[1] D-space enable.
  - Undefined: supervisor-set reads return 0 and writes are ignored. Supervisor accesses abort as non-resident when mapping is enabled, and pass through when mapping is disabled.

## Test plan
- Reset release with SR0=0: read va 0o001000 → pa 0o001000. Read va 0o177560 → pa 0o17777560. No abort.
- Kernel I PAR0 = 0o2000 and PDR0 = 0o077406, SR0=1, SR3=0o20: read va 0o000100 → pa 0o200100, no abort, and PDR0 reads 0o077506 (A set).
- Set PDR0.PLF=0 and ED=0, then read va 0o000100 (block 1): abort. SR0 = 0o040001, and a second faulting access leaves SR0 unchanged.
- User PDR ACF=2: user write → abort with SR0[13]=1 and SR0[6:5]=11. User read of the same page succeeds.
- SR0[9]=1 and ACF=5: write → signal_trap=1, SR0[12] set, W set. Read → no trap.
- Fetch read of va 0o001234 with mapping enabled → SR2 = 0o001234. A subsequent abort freezes SR2 at that value.
